// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial adder controller.
// The requester drives the operation fields; the controller drives status and result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell reused LSB first over WIDTH clocks,
// with operand/result shift registers, carry flop, bit counter and start/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_r_sr;
    logic [CW-1:0]    r_count;
    logic             r_carry;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_x;
    logic             w_y;
    logic             w_f;
    logic             w_g;
    logic             w_p;
    logic             w_carry_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_r_nxt;

    // The shared full-adder cell, fed from bit 0 of the operand shift registers.
    assign w_x         = r_a_sr[0];
    assign w_y         = r_b_sr[0];
    assign w_f         = w_x ^ w_y ^ r_carry;
    assign w_g         = w_x & w_y;
    assign w_p         = w_x | w_y;
    assign w_carry_nxt = w_g | (w_p & r_carry);
    assign w_r_nxt     = {w_f, r_r_sr[WIDTH-1:1]};
    assign w_last      = (r_count == LAST);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:                 w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every datapath flop is reset, so an aborted operation leaves no stale result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_r_sr  <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.op_sub ? ~bus.b : bus.b;
                        r_carry <= bus.op_sub;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_r_sr  <= w_r_nxt;
                    r_carry <= w_carry_nxt;
                    if (w_last) begin
                        // r_carry is still the carry into the MSB on this edge.
                        r_sum  <= w_r_nxt;
                        r_cout <= w_carry_nxt;
                        r_ovf  <= r_carry ^ w_carry_nxt;
                        r_zero <= (w_r_nxt == '0);
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, handshake corner cases,
// asynchronous abort, and randomized operations against an arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        vec_t v;
        int   sa;
        int   sb;
        int   r;
        int   ua;
        int   ub;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        r  = sub ? (sa - sb) : (sa + sb);
        v.a    = a;
        v.b    = b;
        v.sub  = sub;
        v.sum  = 8'(sub ? (ua - ub) : (ua + ub));
        v.cout = sub ? (ua >= ub) : ((ua + ub) > 255);
        v.ovf  = (r > 127) || (r < -128);
        v.zero = (v.sum == 8'h00);
        return v;
    endfunction

    // Called at a negedge in IDLE; returns just after the accepting edge with junk on the inputs.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sub);
        bus.start  = 1'b1;
        bus.a      = a;
        bus.b      = b;
        bus.op_sub = sub;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.a      = 8'($urandom);
        bus.b      = 8'($urandom);
        bus.op_sub = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else          lat++;
        end
    endtask

    task automatic run_and_check(input string name, input vec_t v);
        int lat;
        bit seen;
        issue(v.a, v.b, v.sub);
        wait_done(lat, seen);
        check({name, " done_seen"}, 32'(seen), 32'd1);
        check({name, " latency"},   32'(lat),  32'(WIDTH));
        check({name, " sum"},       32'(bus.sum),  32'(v.sum));
        check({name, " cout"},      32'(bus.cout), 32'(v.cout));
        check({name, " ovf"},       32'(bus.ovf),  32'(v.ovf));
        check({name, " zero"},      32'(bus.zero), 32'(v.zero));
        @(negedge clk);
        check({name, " done_1cyc"}, 32'({bus.done, bus.busy}), 32'd0);
    endtask

    vec_t vecs[$];
    vec_t v;
    int   pulses;
    logic [7:0] held_sum;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;

        vecs.push_back('{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h5A, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1});

        repeat (3) @(negedge clk);
        check("reset outputs", 32'({bus.busy, bus.done, bus.cout, bus.ovf, bus.zero, bus.sum}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", 32'({bus.busy, bus.done}), 32'd0);

        // Directed table; back-to-back issue starts in the first IDLE cycle each time.
        for (int i = 0; i < vecs.size(); i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Outputs hold through idle cycles.
        held_sum = bus.sum;
        repeat (4) @(negedge clk);
        check("sum held in idle", 32'(bus.sum), 32'(held_sum));

        // start pulsed during RUN and during DONE must be ignored.
        issue(8'h35, 8'h4A, 1'b0);
        pulses   = 0;
        held_sum = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (i == 3) begin
                bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.op_sub = 1'b1;
            end
            if (bus.done) begin
                pulses++;
                held_sum  = bus.sum;
                bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.op_sub = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("ignored start: one done", 32'(pulses),   32'd1);
        check("ignored start: result",   32'(held_sum), 32'h7F);
        check("ignored start: sum held", 32'(bus.sum),  32'h7F);
        check("ignored start: idle",     32'(bus.busy), 32'd0);

        // Asynchronous abort just after the 4th RUN edge.
        issue(8'h11, 8'h22, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort outputs cleared", 32'({bus.busy, bus.done, bus.cout, bus.ovf, bus.zero, bus.sum}), 32'd0);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (bus.done) pulses++;
        end
        check("abort: no done", 32'(pulses), 32'd0);
        check("after abort outputs", 32'({bus.busy, bus.done, bus.cout, bus.ovf, bus.zero, bus.sum}), 32'd0);
        run_and_check("post-abort add", '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0});

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            v = model(8'($urandom), 8'($urandom), 1'($urandom));
            run_and_check($sformatf("rand%0d", i), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
